// File: rtl/mult_operand_streamer.sv
// Host-side operand streamer for the chunked big-number multiplier: buffers two
// operands chunk by chunk, streams them LSB first, then echoes the product stream.
module mult_operand_streamer #(
  parameter int REGISTER_SIZE = 32,
  parameter int BITS_IN_NUM   = 2048
) (
  input  logic                     clk_in,
  input  logic                     rst_in,
  input  logic [REGISTER_SIZE-1:0] load_n_in,
  input  logic [REGISTER_SIZE-1:0] load_m_in,
  input  logic                     load_valid_in,
  output logic                     load_ready_out,
  input  logic                     start_in,
  output logic [REGISTER_SIZE-1:0] n_out,
  output logic [REGISTER_SIZE-1:0] m_out,
  output logic                     valid_out,
  input  logic                     mult_ready_in,
  input  logic [REGISTER_SIZE-1:0] prod_in,
  input  logic                     prod_valid_in,
  output logic [REGISTER_SIZE-1:0] result_out,
  output logic                     result_valid_out,
  output logic                     result_last_out,
  output logic                     done_out,
  output logic                     busy_out
);

  localparam int NUM_CHUNKS = BITS_IN_NUM / REGISTER_SIZE;
  localparam int PTR_W      = $clog2(NUM_CHUNKS);
  localparam int CNT_W      = $clog2(2 * NUM_CHUNKS);

  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(NUM_CHUNKS - 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(2 * NUM_CHUNKS - 1);
  localparam logic [PTR_W-1:0] PTR_ZERO = {PTR_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [REGISTER_SIZE-1:0] CHUNK_ZERO = {REGISTER_SIZE{1'b0}};

  typedef enum logic [2:0] {
    ST_LOAD       = 3'd0,
    ST_FULL       = 3'd1,
    ST_WAIT_READY = 3'd2,
    ST_SEND       = 3'd3,
    ST_COLLECT    = 3'd4
  } state_t;

  state_t state_r;
  state_t next_state_s;

  logic [REGISTER_SIZE-1:0] n_buf_r [NUM_CHUNKS];
  logic [REGISTER_SIZE-1:0] m_buf_r [NUM_CHUNKS];

  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [CNT_W-1:0] prod_cnt_r;

  logic [REGISTER_SIZE-1:0] n_out_r;
  logic [REGISTER_SIZE-1:0] m_out_r;
  logic                     valid_r;
  logic [REGISTER_SIZE-1:0] result_r;
  logic                     result_valid_r;
  logic                     result_last_r;
  logic                     done_r;

  logic [PTR_W-1:0]         wr_ptr_nxt_s;
  logic [PTR_W-1:0]         rd_ptr_nxt_s;
  logic [PTR_W-1:0]         rd_ptr_inc_s;
  logic [CNT_W-1:0]         prod_cnt_nxt_s;
  logic [REGISTER_SIZE-1:0] n_out_nxt_s;
  logic [REGISTER_SIZE-1:0] m_out_nxt_s;
  logic                     valid_nxt_s;
  logic [REGISTER_SIZE-1:0] result_nxt_s;
  logic                     result_valid_nxt_s;
  logic                     result_last_nxt_s;
  logic                     buf_we_s;
  logic                     load_last_s;
  logic                     send_last_s;
  logic                     prod_last_s;

  assign load_last_s  = load_valid_in && (wr_ptr_r == LAST_PTR);
  assign send_last_s  = (rd_ptr_r == LAST_PTR);
  assign prod_last_s  = prod_valid_in && (prod_cnt_r == LAST_CNT);
  assign rd_ptr_inc_s = rd_ptr_r + 1'b1;

  // State register
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_r <= ST_LOAD;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state logic; start_in is only honoured once the buffer is full
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      ST_LOAD: begin
        if (load_last_s) next_state_s = ST_FULL;
        else             next_state_s = ST_LOAD;
      end
      ST_FULL: begin
        if (start_in) next_state_s = ST_WAIT_READY;
        else          next_state_s = ST_FULL;
      end
      ST_WAIT_READY: begin
        if (mult_ready_in) next_state_s = ST_SEND;
        else               next_state_s = ST_WAIT_READY;
      end
      ST_SEND: begin
        if (send_last_s) next_state_s = ST_COLLECT;
        else             next_state_s = ST_SEND;
      end
      ST_COLLECT: begin
        if (prod_last_s) next_state_s = ST_LOAD;
        else             next_state_s = ST_COLLECT;
      end
      default: next_state_s = ST_LOAD;
    endcase
  end

  // State-decoded outputs
  always_comb begin
    load_ready_out = 1'b0;
    busy_out       = 1'b0;
    case (state_r)
      ST_LOAD:       load_ready_out = 1'b1;
      ST_FULL:       busy_out       = 1'b0;
      ST_WAIT_READY: busy_out       = 1'b1;
      ST_SEND:       busy_out       = 1'b1;
      ST_COLLECT:    busy_out       = 1'b1;
      default: begin
        load_ready_out = 1'b0;
        busy_out       = 1'b0;
      end
    endcase
  end

  // Next values for pointers and registered outputs
  always_comb begin
    buf_we_s           = 1'b0;
    wr_ptr_nxt_s       = wr_ptr_r;
    rd_ptr_nxt_s       = rd_ptr_r;
    prod_cnt_nxt_s     = prod_cnt_r;
    n_out_nxt_s        = n_out_r;
    m_out_nxt_s        = m_out_r;
    valid_nxt_s        = 1'b0;
    result_nxt_s       = result_r;
    result_valid_nxt_s = 1'b0;
    result_last_nxt_s  = 1'b0;
    case (state_r)
      ST_LOAD: begin
        if (load_valid_in) begin
          buf_we_s = 1'b1;
          if (load_last_s) wr_ptr_nxt_s = PTR_ZERO;
          else             wr_ptr_nxt_s = wr_ptr_r + 1'b1;
        end else begin
          buf_we_s = 1'b0;
        end
      end
      ST_FULL: begin
        buf_we_s = 1'b0;
      end
      ST_WAIT_READY: begin
        // Chunk 0 is staged on the ready edge so it appears on the next cycle
        if (mult_ready_in) begin
          rd_ptr_nxt_s = PTR_ZERO;
          n_out_nxt_s  = n_buf_r[0];
          m_out_nxt_s  = m_buf_r[0];
          valid_nxt_s  = 1'b1;
        end else begin
          valid_nxt_s  = 1'b0;
        end
      end
      ST_SEND: begin
        // rd_ptr_r tracks the chunk currently presented on n_out/m_out
        if (send_last_s) begin
          valid_nxt_s    = 1'b0;
          prod_cnt_nxt_s = CNT_ZERO;
        end else begin
          rd_ptr_nxt_s = rd_ptr_inc_s;
          n_out_nxt_s  = n_buf_r[rd_ptr_inc_s];
          m_out_nxt_s  = m_buf_r[rd_ptr_inc_s];
          valid_nxt_s  = 1'b1;
        end
      end
      ST_COLLECT: begin
        if (prod_valid_in) begin
          result_nxt_s       = prod_in;
          result_valid_nxt_s = 1'b1;
          result_last_nxt_s  = prod_last_s;
          prod_cnt_nxt_s     = prod_cnt_r + 1'b1;
        end else begin
          result_valid_nxt_s = 1'b0;
        end
      end
      default: begin
        buf_we_s = 1'b0;
      end
    endcase
  end

  // Pointer and output registers
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      wr_ptr_r       <= PTR_ZERO;
      rd_ptr_r       <= PTR_ZERO;
      prod_cnt_r     <= CNT_ZERO;
      n_out_r        <= CHUNK_ZERO;
      m_out_r        <= CHUNK_ZERO;
      valid_r        <= 1'b0;
      result_r       <= CHUNK_ZERO;
      result_valid_r <= 1'b0;
      result_last_r  <= 1'b0;
      done_r         <= 1'b0;
    end else begin
      wr_ptr_r       <= wr_ptr_nxt_s;
      rd_ptr_r       <= rd_ptr_nxt_s;
      prod_cnt_r     <= prod_cnt_nxt_s;
      n_out_r        <= n_out_nxt_s;
      m_out_r        <= m_out_nxt_s;
      valid_r        <= valid_nxt_s;
      result_r       <= result_nxt_s;
      result_valid_r <= result_valid_nxt_s;
      result_last_r  <= result_last_nxt_s;
      done_r         <= result_last_nxt_s;
    end
  end

  // Operand buffer; contents persist across transfers until overwritten
  always_ff @(posedge clk_in) begin
    if (buf_we_s) begin
      n_buf_r[wr_ptr_r] <= load_n_in;
      m_buf_r[wr_ptr_r] <= load_m_in;
    end
  end

  assign n_out            = n_out_r;
  assign m_out            = m_out_r;
  assign valid_out        = valid_r;
  assign result_out       = result_r;
  assign result_valid_out = result_valid_r;
  assign result_last_out  = result_last_r;
  assign done_out         = done_r;

endmodule

// File: tb/tb_mult_operand_streamer.sv
// Randomized self-checking bench for mult_operand_streamer (4 chunks of 8 bits).
module tb_mult_operand_streamer;

  localparam int RS = 8;
  localparam int BN = 32;
  localparam int NC = BN / RS;
  localparam int NP = 2 * NC;

  logic          clk_in = 1'b0;
  logic          rst_in;
  logic [RS-1:0] load_n_in, load_m_in;
  logic          load_valid_in, load_ready_out, start_in;
  logic [RS-1:0] n_out, m_out;
  logic          valid_out, mult_ready_in;
  logic [RS-1:0] prod_in;
  logic          prod_valid_in;
  logic [RS-1:0] result_out;
  logic          result_valid_out, result_last_out, done_out, busy_out;

  int vec_cnt = 0;
  int err_cnt = 0;

  // Reference model: the operand chunks most recently accepted by the buffer
  logic [RS-1:0] mdl_n [NC];
  logic [RS-1:0] mdl_m [NC];

  mult_operand_streamer #(.REGISTER_SIZE(RS), .BITS_IN_NUM(BN)) dut (
    .clk_in(clk_in), .rst_in(rst_in),
    .load_n_in(load_n_in), .load_m_in(load_m_in),
    .load_valid_in(load_valid_in), .load_ready_out(load_ready_out),
    .start_in(start_in), .n_out(n_out), .m_out(m_out), .valid_out(valid_out),
    .mult_ready_in(mult_ready_in), .prod_in(prod_in), .prod_valid_in(prod_valid_in),
    .result_out(result_out), .result_valid_out(result_valid_out),
    .result_last_out(result_last_out), .done_out(done_out), .busy_out(busy_out)
  );

  always #5 clk_in = ~clk_in;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_ld_rdy"}, load_ready_out, 1);
    check({tag, "_busy"}, busy_out, 0);
    check({tag, "_valid"}, valid_out, 0);
    check({tag, "_n"}, n_out, 0);
    check({tag, "_m"}, m_out, 0);
    check({tag, "_res"}, result_out, 0);
    check({tag, "_rv"}, result_valid_out, 0);
    check({tag, "_last"}, result_last_out, 0);
    check({tag, "_done"}, done_out, 0);
  endtask

  task automatic do_load(input logic [BN-1:0] n, input logic [BN-1:0] m,
                         input bit early_start, input bit stray, input bit gaps);
    for (int i = 0; i < NC; i++) begin
      if (gaps) begin
        repeat ($urandom_range(0, 2)) begin
          load_valid_in = 1'b0;
          start_in      = early_start;
          prod_valid_in = stray;
          prod_in       = RS'($urandom);
          tick();
          check("ld_gap_rdy", load_ready_out, 1);
          check("ld_gap_rv", result_valid_out, 0);
        end
      end
      load_n_in     = n[i*RS +: RS];
      load_m_in     = m[i*RS +: RS];
      load_valid_in = 1'b1;
      start_in      = early_start;
      prod_valid_in = stray;
      prod_in       = RS'($urandom);
      check("ld_rdy", load_ready_out, 1);
      tick();
      check("ld_rv", result_valid_out, 0);
      mdl_n[i] = n[i*RS +: RS];
      mdl_m[i] = m[i*RS +: RS];
    end
    load_valid_in = 1'b0;
    start_in      = 1'b0;
    prod_valid_in = 1'b0;
    check("full_rdy", load_ready_out, 0);
    check("full_busy", busy_out, 0);
  endtask

  task automatic overrun(input bit stray);
    repeat (2) begin
      load_valid_in = 1'b1;
      load_n_in     = RS'($urandom);
      load_m_in     = RS'($urandom);
      prod_valid_in = stray;
      prod_in       = RS'($urandom);
      tick();
      check("ovr_rdy", load_ready_out, 0);
      check("ovr_busy", busy_out, 0);
      check("ovr_rv", result_valid_out, 0);
    end
    load_valid_in = 1'b0;
    prod_valid_in = 1'b0;
  endtask

  // Starts a transfer, holds ready low for 'stall' cycles, then checks the stream
  task automatic stream(input int stall, input int abort_after);
    start_in      = 1'b1;
    mult_ready_in = (stall == 0);
    tick();
    start_in = 1'b0;
    check("wr_busy", busy_out, 1);
    check("wr_valid", valid_out, 0);
    for (int s = 0; s < stall; s++) begin
      tick();
      check("stall_valid", valid_out, 0);
      check("stall_busy", busy_out, 1);
    end
    mult_ready_in = 1'b1;
    tick();
    for (int i = 0; i < NC; i++) begin
      check("snd_valid", valid_out, 1);
      check("snd_n", n_out, mdl_n[i]);
      check("snd_m", m_out, mdl_m[i]);
      if (i + 1 == abort_after) return;
      mult_ready_in = 1'($urandom);
      tick();
    end
    mult_ready_in = 1'b0;
    check("post_valid", valid_out, 0);
    check("col_busy", busy_out, 1);
  endtask

  // Feeds the product stream; gap_before inserts a 3-cycle hole before that chunk
  task automatic collect(input int gap_before, input bit rand_vals);
    logic [RS-1:0] val;
    int ng;
    for (int k = 0; k < NP; k++) begin
      ng = (k == gap_before) ? 3 : (rand_vals ? int'($urandom_range(0, 2)) : 0);
      repeat (ng) begin
        prod_valid_in = 1'b0;
        prod_in       = RS'($urandom);
        tick();
        check("gap_rv", result_valid_out, 0);
        check("gap_done", done_out, 0);
      end
      val           = rand_vals ? RS'($urandom) : RS'(8'h10 + k);
      prod_in       = val;
      prod_valid_in = 1'b1;
      tick();
      check("col_rv", result_valid_out, 1);
      check("col_res", result_out, val);
      check("col_last", result_last_out, (k == NP - 1));
      check("col_done", done_out, (k == NP - 1));
    end
    prod_valid_in = 1'b0;
    check("end_rdy", load_ready_out, 1);
    check("end_busy", busy_out, 0);
    tick();
    check("end_rv", result_valid_out, 0);
    check("end_done", done_out, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_in        = 1'b1;
    load_n_in     = '0;
    load_m_in     = '0;
    load_valid_in = 1'b0;
    start_in      = 1'b0;
    mult_ready_in = 1'b0;
    prod_in       = '0;
    prod_valid_in = 1'b0;
    repeat (2) tick();
    check_idle("rst");
    rst_in = 1'b0;
    tick();
    check_idle("post_rst");

    // Basic flow with early start, stray products and overrun in FULL
    do_load(32'h04030201, 32'h08070605, 1'b1, 1'b1, 1'b0);
    overrun(1'b1);
    stream(0, 0);
    collect(2, 1'b0);

    // Ready stall
    do_load(BN'($urandom), BN'($urandom), 1'b0, 1'b0, 1'b1);
    stream(10, 0);
    collect(-1, 1'b1);

    // Random rounds
    for (int r = 0; r < 6; r++) begin
      do_load(BN'($urandom), BN'($urandom), 1'($urandom), 1'($urandom), 1'b1);
      if ($urandom_range(0, 1) == 1) overrun(1'($urandom));
      stream(int'($urandom_range(0, 3)), 0);
      collect(-1, 1'b1);
    end

    // Asynchronous reset mid-SEND, between clock edges
    do_load(BN'($urandom), BN'($urandom), 1'b0, 1'b0, 1'b0);
    stream(0, 2);
    #3 rst_in = 1'b1;
    #1 check_idle("arst");
    #2 rst_in = 1'b0;
    tick();
    check_idle("arst_rel");
    do_load(BN'($urandom), BN'($urandom), 1'b0, 1'b0, 1'b0);
    stream(0, 0);
    collect(-1, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/mult_operand_streamer.md
# mult_operand_streamer

Host-side partner of the chunked big-number multiplier. Buffers two BITS_IN_NUM-bit operands as REGISTER_SIZE-bit chunks, waits for the multiplier's ready, and streams both operands to it LSB chunk first. It then collects the 2·BITS_IN_NUM-bit product stream, tags the final chunk and pulses done. It sits between the election datapath (operand source / result sink) and the multiplier core.

## Interface
- REGISTER_SIZE, 32, chunk width in bits
- BITS_IN_NUM, 2048, operand width; NUM_CHUNKS = BITS_IN_NUM/REGISTER_SIZE, must be an integer ≥ 2
- clk_in  input  1  sole clock, rising edge
- rst_in  input  1  reset; asynchronous, active-high
- load_n_in  input  REGISTER_SIZE  operand n chunk, LSB chunk first
- load_m_in  input  REGISTER_SIZE  operand m chunk, same index as load_n_in
- load_valid_in  input  1  chunk pair present; accepted when load_ready_out=1
- load_ready_out  output  1  buffer accepting chunks (state LOAD)
- start_in  input  1  begin transfer; honoured only in FULL
- n_out, m_out  output  REGISTER_SIZE each  chunk pair to multiplier (its n_in/m_in)
- valid_out  output  1  chunk pair valid (multiplier valid_in)
- mult_ready_in  input  1  multiplier ready_out
- prod_in  input  REGISTER_SIZE  product chunk from multiplier
- prod_valid_in  input  1  product chunk valid
- result_out  output  REGISTER_SIZE  registered product chunk
- result_valid_out  output  1  result_out valid
- result_last_out  output  1  high with product chunk 2·NUM_CHUNKS−1
- done_out  output  1  one-cycle pulse, coincident with result_last_out
- busy_out  output  1  state ∉ {LOAD, FULL}

## Operation
- Storage: two NUM_CHUNKS×REGISTER_SIZE arrays (n, m); wr_ptr, rd_ptr of $clog2(NUM_CHUNKS) bits; prod_cnt of $clog2(2·NUM_CHUNKS) bits.
- States: LOAD, FULL, WAIT_READY, SEND, COLLECT. Reset state LOAD.
- LOAD: load_ready_out=1. Each load_valid_in cycle writes both chunks at wr_ptr and increments it. The write at wr_ptr=NUM_CHUNKS−1 → FULL, wr_ptr←0. start_in is ignored, including in the same cycle as the final write.
- FULL: load_ready_out=0; load_valid_in is ignored. start_in=1 → WAIT_READY.
- WAIT_READY: mult_ready_in=1 → SEND with rd_ptr←0. Otherwise hold indefinitely.
- SEND: valid_out=1 every cycle, n_out/m_out = buffer[rd_ptr], rd_ptr increments. No backpressure. After the cycle presenting chunk NUM_CHUNKS−1 → COLLECT, prod_cnt←0.
- COLLECT: each prod_valid_in registers prod_in to result_out with result_valid_out=1 and increments prod_cnt. At prod_cnt=2·NUM_CHUNKS−1, also assert result_last_out and done_out, then → LOAD.
- prod_valid_in outside COLLECT is ignored: no result_valid_out, no count change.
- Buffer contents survive the return to LOAD and are overwritten by the next load.

## Timing
- Reset (async assert, synchronous release): state LOAD; load_ready_out=1; valid_out, result_valid_out, result_last_out, done_out, busy_out=0; n_out, m_out, result_out=0; all pointers 0.
- Reset mid-SEND/COLLECT: everything returns to the reset values immediately; the partial transfer is abandoned. The multiplier shares rst_in.
- All outputs except load_ready_out and busy_out are registered. load_ready_out and busy_out decode state.
- start_in at cycle t in FULL, mult_ready_in high → WAIT_READY at t+1, first valid_out at t+2. Chunks follow on exactly NUM_CHUNKS consecutive cycles with no bubbles.
- mult_ready_in is sampled only in WAIT_READY.
- Result latency: prod_in at cycle t → result_out at t+1. Gaps in prod_valid_in are tolerated.
- Minimum round trip: NUM_CHUNKS load cycles + 2 + NUM_CHUNKS + product stream.

## Test plan
Parameters for all scenarios: REGISTER_SIZE=8, BITS_IN_NUM=32 (NUM_CHUNKS=4, 8 product chunks).
- Basic flow: load n=0x04030201, m=0x08070605 on 4 consecutive cycles, pulse start_in, mult_ready_in=1 → valid_out for exactly 4 cycles, n_out 01,02,03,04 and m_out 05,06,07,08, first valid_out 2 cycles after start_in.
- Ready stall: start_in with mult_ready_in=0 for 10 cycles → valid_out stays 0 and state holds WAIT_READY. Raise ready → stream begins 1 cycle later.
- Early start and overrun: start_in during LOAD, including with the 4th chunk → ignored. load_valid_in in FULL → buffer unchanged, stream still 01..04.
- Collect: feed 8 product chunks 0x10..0x17 with a 3-cycle gap after the 2nd → result_out echoes each 1 cycle later; result_last_out and done_out high only with 0x17; then load_ready_out=1.
- Stray product: prod_valid_in=1 in LOAD and FULL → no result_valid_out, and a later collect still needs all 8 chunks.
- Async reset mid-SEND after 2 chunks → outputs at reset values without waiting for a clock edge. A fresh load and start then streams correctly from chunk 0.
